// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns a shared 4->1 mux and exposes the owner's data bit.
// Define ARB_TIMEOUT_EN to bound each grant to MAX_HOLD consecutive cycles.

module mux4 (
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic [1:0] s,
    output logic       y
);
    always_comb begin
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule

module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       z
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0] state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] scan_start;
    logic [1:0] winner;
    logic       mux_y;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    // Without the timeout MAX_HOLD is inert; an illegal value only shows up as this marker block.
    if (MAX_HOLD < 2) begin : g_max_hold_out_of_range
    end
`endif

    // First requester at or after start, wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        rr_pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    // While granted, any new winner is searched from owner+1 so the owner ranks last.
    assign scan_start = (state_q == S_IDLE) ? ptr_q : sel_q + 2'd1;
    assign winner     = rr_pick(req, scan_start);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_GRANT;
                    sel_d   = winner;
                    gnt_d   = 4'b0001 << winner;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            default: begin
                if (!req[sel_q]) begin
                    ptr_d = sel_q + 2'd1;
                    if (|req) begin
                        sel_d = winner;
                        gnt_d = 4'b0001 << winner;
                    end else begin
                        state_d = S_IDLE;
                        sel_d   = 2'd0;
                        gnt_d   = 4'b0000;
                    end
`ifdef ARB_TIMEOUT_EN
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    cnt_d = '0;
                    if (|(req & ~gnt_q)) begin
                        ptr_d = sel_q + 2'd1;
                        sel_d = winner;
                        gnt_d = 4'b0001 << winner;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    mux4 u_mux4 (
        .d0 (d[0]),
        .d1 (d[1]),
        .d2 (d[2]),
        .d3 (d[3]),
        .s  (sel_q),
        .y  (mux_y)
    );

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = |gnt_q;
    assign z    = busy & mux_y;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a behavioural model pushes expected outputs per cycle.
`timescale 1ns/1ps

module tb_mux4_rr_arbiter;
    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       z;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .d    (d),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy),
        .z    (z)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       z;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    logic m_busy  = 1'b0;
    int   m_owner = 0;
    int   m_ptr   = 0;
    int   m_cnt   = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int first_from(input int start, input logic [3:0] r);
        for (int k = 0; k < 4; k++)
            if (r[(start + k) % 4]) return (start + k) % 4;
        return start;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] rq);
        if (r) begin
            m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        end else if (!m_busy) begin
            if (rq != 4'b0) begin
                m_busy  = 1'b1;
                m_owner = first_from(m_ptr, rq);
                m_cnt   = 0;
            end
        end else if (!rq[m_owner]) begin
            m_ptr = (m_owner + 1) % 4;
            m_cnt = 0;
            if (rq != 4'b0) m_owner = first_from(m_ptr, rq);
            else begin
                m_busy  = 1'b0;
                m_owner = 0;
            end
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (m_cnt == MAX_HOLD - 1) begin
                m_cnt = 0;
                if ((rq & ~(4'b0001 << m_owner)) != 4'b0) begin
                    m_ptr   = (m_owner + 1) % 4;
                    m_owner = first_from(m_ptr, rq);
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
`endif
        end
    endtask

    // Drive one cycle of stimulus, push the model's expectation, then compare after the edge.
    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] dd);
        exp_t e;
        rst = r;
        req = rq;
        d   = dd;
        model_step(r, rq);
        e.gnt  = m_busy ? 4'(4'b0001 << m_owner) : 4'b0000;
        e.sel  = m_busy ? 2'(m_owner) : 2'd0;
        e.busy = m_busy;
        e.z    = m_busy ? dd[m_owner] : 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("gnt",  8'(gnt),  8'(e.gnt));
        check("sel",  8'(sel),  8'(e.sel));
        check("busy", 8'(busy), 8'(e.busy));
        check("z",    8'(z),    8'(e.z));
    endtask

    initial begin
        int         order[$];
        int         held;
        int         prev_owner;
        logic [3:0] prev_gnt;
        logic [3:0] rq;
        int         want_order[5];

        rst = 1'b1;
        req = 4'b0000;
        d   = 4'b0000;

        // Reset with all requesting, then the first grant one edge after release
        drive(1'b1, 4'b1111, 4'b1111);
        drive(1'b1, 4'b1111, 4'b1111);
        check("rst_gnt", 8'(gnt), 8'h00);
        check("rst_z",   8'(z),   8'h00);
        drive(1'b0, 4'b1111, 4'b1111);
        check("first_gnt", 8'(gnt), 8'h01);
        drive(1'b0, 4'b0000, 4'b0000);

        // Single requester holding 5 cycles with its data bit high
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'b0100, 4'b0100);
            check("single_gnt", 8'(gnt), 8'h04);
            check("single_z",   8'(z),   8'h01);
        end
        drive(1'b0, 4'b0000, 4'b0100);
        check("single_idle", 8'(busy), 8'h00);

        // Back-to-back handoff from reset: each owner holds 3 cycles, then drops
        drive(1'b1, 4'b1111, 4'b0000);
        held       = 0;
        prev_owner = -1;
        prev_gnt   = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            rq = 4'b1111;
            if (m_busy && held == 3) rq = rq & ~(4'b0001 << m_owner);
            drive(1'b0, rq, 4'($urandom_range(0, 15)));
            if (m_busy && m_owner == prev_owner) held++;
            else held = 1;
            prev_owner = m_busy ? m_owner : -1;
            if (gnt != prev_gnt && gnt != 4'b0000) order.push_back(int'(sel));
            prev_gnt = gnt;
        end
        want_order = '{0, 1, 2, 3, 0};
        check("order_len", 8'(order.size() >= 5), 8'h01);
        for (int i = 0; i < 5; i++)
            if (i < order.size()) check("order", 8'(order[i]), 8'(want_order[i]));

        // Pointer wrap: owner 3 releases while 0 and 1 request
        drive(1'b1, 4'b0000, 4'b0000);
        drive(1'b0, 4'b1000, 4'b0000);
        check("wrap_owner3", 8'(gnt), 8'h08);
        drive(1'b0, 4'b0011, 4'b0000);
        check("wrap_gnt", 8'(gnt), 8'h01);

        // Reset in the middle of a grant, then ptr restarts at 0
        drive(1'b1, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0100, 4'b1111);
        check("mid_owner2", 8'(gnt), 8'h04);
        drive(1'b1, 4'b0100, 4'b1111);
        check("mid_rst_gnt", 8'(gnt), 8'h00);
        drive(1'b0, 4'b0110, 4'b1111);
        check("mid_after", 8'(gnt), 8'h02);

        // Two requesters held constant
        drive(1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 8; i++) drive(1'b0, 4'b0011, 4'b0001);
        check("hold8_owner0", 8'(gnt), 8'h01);
        drive(1'b0, 4'b0011, 4'b0001);
`ifdef ARB_TIMEOUT_EN
        check("timeout_switch", 8'(gnt), 8'h02);
`else
        check("no_timeout", 8'(gnt), 8'h01);
`endif
        for (int i = 0; i < 20; i++) drive(1'b0, 4'b0011, 4'($urandom_range(0, 15)));

        // Lone requester is never revoked
        drive(1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 20; i++) drive(1'b0, 4'b0001, 4'b0001);
        check("lone_hold", 8'(gnt), 8'h01);

        // Random traffic with occasional resets
        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
